barrel_shifter_pipe: RTL

BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

---
 rtl/barrel_shifter_pipe_if.sv | 27 ++
 rtl/barrel_shifter_pipe.sv | 120 ++++++++++++
 2 files changed

// File: rtl/barrel_shifter_pipe_if.sv
// Handshake bundle for barrel_shifter_pipe: operation request in, shifted result out.
interface barrel_shifter_pipe_if #(
  parameter int WIDTH = 16
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_err;

  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_err
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_err
  );
endinterface

// File: rtl/barrel_shifter_pipe.sv
// Pipelined logarithmic barrel shifter: stage k shifts by 2^k, one result per cycle,
// whole pipe stalls together on downstream backpressure.
module barrel_shifter_pipe #(
  parameter int WIDTH = 16
) (
  input logic                clk,
  input logic                rst_n,
  barrel_shifter_pipe_if.slave bus
);
  localparam int SHW  = $clog2(WIDTH);
  localparam int LAST = SHW - 1;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       op,
    input logic             sign,
    input logic             en,
    input int               amt
  );
    logic signed [WIDTH-1:0] sd;
    logic        [WIDTH-1:0] r;
    sd = $signed({sign, d[WIDTH-2:0]});
    r  = d;
    if (en) begin
      case (op)
        OP_SLL:  r = d << amt;
        OP_SRL:  r = d >> amt;
        OP_SRA:  r = $unsigned(sd >>> amt);
        OP_ROL:  r = (d << amt) | (d >> (WIDTH - amt));
        OP_ROR:  r = (d >> amt) | (d << (WIDTH - amt));
        default: r = d;
      endcase
    end
    return r;
  endfunction

  logic advance;

  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  for (genvar k = 0; k < SHW; k++) begin : g_st
    logic             vld_p;
    logic [WIDTH-1:0] data_p;
    logic [2:0]       op_p;

    logic             src_vld;
    logic [WIDTH-1:0] src_data;
    logic [2:0]       src_op;
    logic             src_sign;
    logic             src_en;

    if (k == 0) begin : g_src
      assign src_vld  = bus.in_valid;
      assign src_data = bus.in_data;
      assign src_op   = bus.in_op;
      assign src_sign = bus.in_data[WIDTH-1];
      assign src_en   = bus.in_shamt[0];
    end else begin : g_src
      assign src_vld  = g_st[k-1].vld_p;
      assign src_data = g_st[k-1].data_p;
      assign src_op   = g_st[k-1].op_p;
      assign src_sign = g_st[k-1].g_fwd.sign_p;
      assign src_en   = g_st[k-1].g_fwd.rest_p[0];
    end

    // stage k boundary: shift by 2^k, forward op/sign and the not-yet-used shamt bits
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p <= 1'b0;
      end else if (advance) begin
        vld_p <= src_vld;
      end
    end

    always_ff @(posedge clk) begin
      if (advance) begin
        data_p <= shift_step(src_data, src_op, src_sign, src_en, 1 << k);
        op_p   <= src_op;
      end
    end

    if (k < LAST) begin : g_fwd
      logic              sign_p;
      logic [SHW-2-k:0]  rest_p;
      logic [SHW-2-k:0]  rest_src;

      if (k == 0) begin : g_rest
        assign rest_src = bus.in_shamt[SHW-1:1];
      end else begin : g_rest
        assign rest_src = g_st[k-1].g_fwd.rest_p[SHW-1-k:1];
      end

      always_ff @(posedge clk) begin
        if (advance) begin
          sign_p <= src_sign;
          rest_p <= rest_src;
        end
      end
    end
  end

  logic             out_vld_c;
  logic [WIDTH-1:0] out_data_c;

  // Invalid final-stage contents are masked so reset and bubbles present a clean zero.
  assign out_vld_c     = g_st[LAST].vld_p;
  assign out_data_c    = out_vld_c ? g_st[LAST].data_p : '0;
  assign bus.out_valid = out_vld_c;
  assign bus.out_data  = out_data_c;
  assign bus.out_zero  = (out_data_c == '0);
  assign bus.out_err   = out_vld_c && (g_st[LAST].op_p > OP_ROR);

endmodule
